// File: rtl/clk_gate_ctrl.sv
// Clock-buffer enable sequencer: wakes the shared gated clock on request,
// grants only after a fixed settle time, and holds it for an idle hysteresis.
module clk_gate_ctrl #(
  parameter int NREQ     = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 4
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            force_on,
  output logic            gate_en,
  output logic [NREQ-1:0] ack,
  output logic            clk_on,
  output logic [1:0]      state,
  output logic [7:0]      wake_cnt
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_t;

  localparam logic [3:0] WAKE_RELOAD = 4'(WAKE_CYC - 1);
  localparam logic [3:0] IDLE_RELOAD = 4'(IDLE_CYC - 1);
  localparam bit PARAMS_OK = (NREQ >= 1) && (NREQ <= 8) &&
                             (WAKE_CYC >= 1) && (WAKE_CYC <= 15) &&
                             (IDLE_CYC >= 1) && (IDLE_CYC <= 15);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            gate_en_q, gate_en_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            clk_on_q, clk_on_d;
  logic [7:0]      wake_cnt_q, wake_cnt_d;

  logic any_req;
  logic any;

  assign any_req = |req;
  assign any     = any_req | force_on;

  // Only a real requester moves the block into ON; force_on alone parks it in
  // WAKE/IDLE so the clock runs with nobody granted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (any) begin
          state_d = ST_WAKE;
          cnt_d   = WAKE_RELOAD;
          if (wake_cnt_q != 8'hFF) wake_cnt_d = wake_cnt_q + 8'd1;
        end
      end
      ST_WAKE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (any_req) begin
          state_d = ST_ON;
          ack_d   = req;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = IDLE_RELOAD;
        end
      end
      ST_ON: begin
        if (any_req) begin
          ack_d = req;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = IDLE_RELOAD;
        end
      end
      ST_IDLE: begin
        // A request on the expiry edge still wins over the shutdown.
        if (any_req) begin
          state_d = ST_ON;
          ack_d   = req;
        end else if (force_on) begin
          cnt_d = IDLE_RELOAD;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
    gate_en_d = (state_d != ST_OFF);
    clk_on_d  = (state_d == ST_ON) || (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= ST_OFF;
      cnt_q      <= 4'd0;
      gate_en_q  <= 1'b0;
      ack_q      <= '0;
      clk_on_q   <= 1'b0;
      wake_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gate_en_q  <= gate_en_d;
      ack_q      <= ack_d;
      clk_on_q   <= clk_on_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  assign gate_en  = gate_en_q;
  assign ack      = ack_q;
  assign clk_on   = clk_on_q;
  assign state    = state_q;
  assign wake_cnt = wake_cnt_q;

  param_legal: assert property (@(posedge clk_in) PARAMS_OK)
    else $error("clk_gate_ctrl: parameter out of legal range");

endmodule
